// File: rtl/branch_resolve_tracker.sv
// In-order tracker of issued branch predictions: each resolved outcome retires the oldest
// pending prediction, flags a mispredict and updates saturating accuracy statistics.
module branch_resolve_tracker #(
    parameter int Direction_SIZE = 32,
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pred_valid,
    input  logic                      pred_taken,
    input  logic [Direction_SIZE-1:0] pred_pc,
    output logic                      pred_ready,
    input  logic                      res_valid,
    input  logic                      res_taken,
    input  logic                      flush,
    output logic                      mispredict,
    output logic [Direction_SIZE-1:0] mispredict_pc,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [CNT_W-1:0]          total_branch,
    output logic [CNT_W-1:0]          correct_count,
    output logic [CNT_W-1:0]          error_count,
    output logic                      overflow_err,
    output logic                      underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [Direction_SIZE-1:0] pc_mem    [DEPTH];
    logic                      taken_mem [DEPTH];

    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [PTR_W:0]            count_reg;
    logic                      mispredict_reg;
    logic [Direction_SIZE-1:0] mispredict_pc_reg;
    logic [CNT_W-1:0]          total_reg;
    logic [CNT_W-1:0]          correct_reg;
    logic [CNT_W-1:0]          error_reg;
    logic                      overflow_reg;
    logic                      underflow_reg;

    logic                      is_full;
    logic                      is_empty;
    logic                      push;
    logic                      pop;
    logic [Direction_SIZE-1:0] head_pc;
    logic                      head_taken;

    assign is_full    = (count_reg == FULL_CNT);
    assign is_empty   = (count_reg == '0);
    assign pred_ready = !is_full;

    // flush wins over both sides: nothing is stored, compared or flagged that cycle
    assign push = pred_valid && !is_full && !flush;
    assign pop  = res_valid && !is_empty && !flush;

    assign head_pc    = pc_mem[rd_ptr_reg];
    assign head_taken = taken_mem[rd_ptr_reg];

    // Storage carries no reset; validity is tracked by the pointers and count alone
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= pred_pc;
            taken_mem[wr_ptr_reg] <= pred_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_reg    <= 1'b0;
            mispredict_pc_reg <= '0;
            total_reg         <= '0;
            correct_reg       <= '0;
            error_reg         <= '0;
        end else begin
            mispredict_reg <= 1'b0;
            if (pop) begin
                if (total_reg != CNT_MAX) begin
                    total_reg <= total_reg + CNT_W'(1);
                end
                if (head_taken == res_taken) begin
                    if (correct_reg != CNT_MAX) begin
                        correct_reg <= correct_reg + CNT_W'(1);
                    end
                end else begin
                    if (error_reg != CNT_MAX) begin
                        error_reg <= error_reg + CNT_W'(1);
                    end
                    mispredict_reg    <= 1'b1;
                    mispredict_pc_reg <= head_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (pred_valid && is_full && !flush) begin
                overflow_reg <= 1'b1;
            end
            if (res_valid && is_empty && !flush) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign mispredict    = mispredict_reg;
    assign mispredict_pc = mispredict_pc_reg;
    assign fifo_count    = count_reg;
    assign total_branch  = total_reg;
    assign correct_count = correct_reg;
    assign error_count   = error_reg;
    assign overflow_err  = overflow_reg;
    assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker: linear stimulus, hand-computed expectations.
module tb_branch_resolve_tracker;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        mispredict;
    logic [31:0] mispredict_pc;
    logic [2:0]  fifo_count;
    logic [31:0] total_branch;
    logic [31:0] correct_count;
    logic [31:0] error_count;
    logic        overflow_err;
    logic        underflow_err;

    int errors = 0;
    int checks = 0;

    branch_resolve_tracker #(
        .Direction_SIZE(32),
        .DEPTH(4),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_pc(pred_pc),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .flush(flush),
        .mispredict(mispredict),
        .mispredict_pc(mispredict_pc),
        .fifo_count(fifo_count),
        .total_branch(total_branch),
        .correct_count(correct_count),
        .error_count(error_count),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("%s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        pred_pc    = 32'h0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        pred_valid = pv;
        pred_pc    = pc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        step();
        $display("txn pv=%0d pc=0x%0h pt=%0d rv=%0d rt=%0d fl=%0d -> cnt=%0d mp=%0d mp_pc=0x%0h tot=%0d ok=%0d err=%0d",
                 pv, pc, pt, rv, rt, fl, fifo_count, mispredict, mispredict_pc,
                 total_branch, correct_count, error_count);
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // Reset state
        step();
        step();
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_total", 64'(total_branch), 64'd0);
        check("rst_mp", 64'(mispredict), 64'd0);
        #4 reset = 1'b1;
        step();
        check("rst_ready", 64'(pred_ready), 64'd1);
        check("rst_correct", 64'(correct_count), 64'd0);
        check("rst_error", 64'(error_count), 64'd0);
        check("rst_mp_pc", 64'(mispredict_pc), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);

        // Basic compare: one mispredict on 0x104
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        check("basic_count3", 64'(fifo_count), 64'd3);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_mp0", 64'(mispredict), 64'd0);
        check("basic_total1", 64'(total_branch), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_mp1", 64'(mispredict), 64'd1);
        check("basic_mp_pc", 64'(mispredict_pc), 64'h104);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_mp2", 64'(mispredict), 64'd0);
        check("basic_total", 64'(total_branch), 64'd3);
        check("basic_correct", 64'(correct_count), 64'd2);
        check("basic_error", 64'(error_count), 64'd1);
        check("basic_mp_pc_held", 64'(mispredict_pc), 64'h104);
        check("basic_count0", 64'(fifo_count), 64'd0);

        // Overflow: 5 pushes into a 4-deep FIFO
        drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_ovf_early", 64'(overflow_err), 64'd0);
        drive(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_ready0", 64'(pred_ready), 64'd0);
        drive(1'b1, 32'h210, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_count4", 64'(fifo_count), 64'd4);
        check("ovf_flag", 64'(overflow_err), 64'd1);
        // Drain with opposite outcomes so every pop reports its PC
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("drain_pc0", 64'(mispredict_pc), 64'h200);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("drain_pc1", 64'(mispredict_pc), 64'h204);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("drain_pc2", 64'(mispredict_pc), 64'h208);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("drain_pc3", 64'(mispredict_pc), 64'h20C);
        check("drain_count0", 64'(fifo_count), 64'd0);
        check("drain_total", 64'(total_branch), 64'd7);
        check("drain_error", 64'(error_count), 64'd5);

        // Underflow: resolve with nothing pending
        check("unf_flag_before", 64'(underflow_err), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unf_flag", 64'(underflow_err), 64'd1);
        check("unf_total", 64'(total_branch), 64'd7);
        check("unf_mp", 64'(mispredict), 64'd0);
        check("unf_mp_pc", 64'(mispredict_pc), 64'h20C);

        // Steady push+pop at count 2 across several pointer wraps
        drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h308 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("wrap_count_%0d", k), 64'(fifo_count), 64'd2);
            check($sformatf("wrap_pc_%0d", k), 64'(mispredict_pc), 64'h300 + 64'(4 * k));
        end
        check("wrap_total", 64'(total_branch), 64'd17);
        check("wrap_correct", 64'(correct_count), 64'd2);
        check("wrap_error", 64'(error_count), 64'd15);

        // Flush with same-cycle push and pop at 3 pending
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        check("flush_pre_count", 64'(fifo_count), 64'd3);
        drive(1'b1, 32'h404, 1'b1, 1'b1, 1'b0, 1'b1);
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_mp", 64'(mispredict), 64'd0);
        check("flush_total", 64'(total_branch), 64'd17);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_total_late", 64'(total_branch), 64'd17);
        check("flush_error_late", 64'(error_count), 64'd15);

        // After flush the FIFO restarts cleanly; then reset mid-pulse
        drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_flush_mp", 64'(mispredict), 64'd1);
        check("post_flush_pc", 64'(mispredict_pc), 64'h500);
        check("post_flush_total", 64'(total_branch), 64'd18);
        idle();
        #2 reset = 1'b0;
        #1;
        check("arst_mp", 64'(mispredict), 64'd0);
        check("arst_count", 64'(fifo_count), 64'd0);
        check("arst_total", 64'(total_branch), 64'd0);
        check("arst_error", 64'(error_count), 64'd0);
        check("arst_mp_pc", 64'(mispredict_pc), 64'd0);
        check("arst_ovf", 64'(overflow_err), 64'd0);
        check("arst_unf", 64'(underflow_err), 64'd0);
        #2 reset = 1'b1;
        step();
        check("arst_ready", 64'(pred_ready), 64'd1);
        // Nothing pending after reset: a resolve must underflow
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("arst_unf_again", 64'(underflow_err), 64'd1);
        check("arst_total_still0", 64'(total_branch), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
